tmds_enc_multi: RTL

Parametrised multi-lane TMDS encoder, the HDMI-capable successor of the single-lane DVI encoder. It encodes CHANNELS lanes in lockstep through a 3-stage pipeline with clock-enable stall. Modes are control, video data, video guard band, TERC4 data island and data-island guard band. Each lane keeps its own running disparity and has an optional output polarity inversion. It sits between the timing/packet generator and the per-lane 10:1 serialisers.

---
 rtl/tmds_enc_multi_if.sv | 32 +++
 rtl/tmds_enc_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_enc_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tmds_enc_multi_if                                             |
// | Purpose  : Bus between the timing/packet generator and the multi-lane    |
// |            TMDS encoder: clock enable, period type, per-lane payloads    |
// |            in; encoded symbols and valid flag out.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface tmds_enc_multi_if #(
  parameter int CHANNELS = 3
) ();
  logic                    ce;
  logic [2:0]              mode;
  logic [8*CHANNELS-1:0]   data;
  logic [2*CHANNELS-1:0]   ctrl;
  logic [4*CHANNELS-1:0]   aux;
  logic [10*CHANNELS-1:0]  tmds;
  logic                    tmds_valid;

  // Source side: timing/packet generator
  modport master (
    output ce, mode, data, ctrl, aux,
    input  tmds, tmds_valid
  );

  // Sink side: the encoder
  modport slave (
    input  ce, mode, data, ctrl, aux,
    output tmds, tmds_valid
  );
endinterface
`default_nettype wire

// File: rtl/tmds_enc_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tmds_enc_multi                                                |
// | Purpose  : CHANNELS-lane TMDS encoder with control, video, video guard,  |
// |            TERC4 data island and island guard periods. 3-stage pipeline |
// |            with clock-enable stall; per-lane running disparity and      |
// |            optional per-lane output inversion.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tmds_enc_multi #(
  parameter int                  CHANNELS = 3,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  logic            clock,
  input  logic            reset,
  tmds_enc_multi_if.slave bus
);

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_IGUARD = 3'd4;

  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  // Population count of a byte
  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, d[k]};
    return n;
  endfunction

  // Transition-minimising stage: XOR or XNOR chain plus the method flag in bit 8
  function automatic logic [8:0] make_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int k = 1; k < 8; k++)
      q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Control-period code for {c1,c0}
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  // TERC4 code for a data-island nibble
  function automatic logic [9:0] terc4(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'd0:    s = 10'b1010011100;
      4'd1:    s = 10'b1001100011;
      4'd2:    s = 10'b1011100100;
      4'd3:    s = 10'b1011100010;
      4'd4:    s = 10'b0101110001;
      4'd5:    s = 10'b0100011110;
      4'd6:    s = 10'b0110001110;
      4'd7:    s = 10'b0100111100;
      4'd8:    s = 10'b1011001100;
      4'd9:    s = 10'b0100111001;
      4'd10:   s = 10'b0110011100;
      4'd11:   s = 10'b1011000110;
      4'd12:   s = 10'b1010001110;
      4'd13:   s = 10'b1001110001;
      4'd14:   s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // DC-balancing stage: returns {next_cnt[5:0], symbol[9:0]}
  function automatic logic [15:0] video_sym(input logic [8:0] qm, input logic signed [5:0] cnt);
    logic [3:0]        n1q;
    logic signed [5:0] diff;
    logic signed [5:0] nxt;
    logic [9:0]        sym;
    n1q  = ones8(qm[7:0]);
    diff = $signed({2'b00, n1q}) - 6'sd4;
    if ((cnt == 6'sd0) || (n1q == 4'd4)) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? (cnt + diff + diff) : (cnt - diff - diff);
    end else if (((cnt > 6'sd0) && (n1q > 4'd4)) || ((cnt < 6'sd0) && (n1q < 4'd4))) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nxt = cnt - diff - diff + (qm[8] ? 6'sd2 : 6'sd0);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nxt = cnt + diff + diff - (qm[8] ? 6'sd0 : 6'sd2);
    end
    return {nxt, sym};
  endfunction

  // Period-type symbol selection for one lane: returns {next_cnt, symbol}
  function automatic logic [15:0] lane_sym(input logic [2:0] m, input int lane,
                                           input logic [8:0] qm, input logic [1:0] c,
                                           input logic [3:0] a, input logic signed [5:0] cnt);
    logic [15:0] r;
    case (m)
      MODE_VIDEO:  r = video_sym(qm, cnt);
      MODE_VGUARD: r = {6'd0, (lane % 3 == 1) ? GUARD_B : GUARD_A};
      MODE_ISLAND: r = {6'd0, terc4(a)};
      MODE_IGUARD: r = {6'd0, (lane % 3 == 0) ? terc4({2'b11, c}) : GUARD_B};
      default:     r = {6'd0, ctrl_sym(c)};
    endcase
    return r;
  endfunction

  logic [2:0]              s1_mode;
  logic [8*CHANNELS-1:0]   s1_data;
  logic [2*CHANNELS-1:0]   s1_ctrl;
  logic [4*CHANNELS-1:0]   s1_aux;
  logic [2:0]              s2_mode;
  logic [9*CHANNELS-1:0]   s2_qm;
  logic [2*CHANNELS-1:0]   s2_ctrl;
  logic [4*CHANNELS-1:0]   s2_aux;
  logic [10*CHANNELS-1:0]  tmds_q;
  logic [6*CHANNELS-1:0]   cnt_q;
  logic [1:0]              fill;

  logic [9*CHANNELS-1:0]   qm_next;
  logic [16*CHANNELS-1:0]  enc_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign qm_next[9*i +: 9]    = make_qm(s1_data[8*i +: 8]);
    assign enc_next[16*i +: 16] = lane_sym(s2_mode, i, s2_qm[9*i +: 9], s2_ctrl[2*i +: 2],
                                           s2_aux[4*i +: 4], cnt_q[6*i +: 6]);
  end

  // Stage 1: capture the period type and per-lane payloads
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_mode <= MODE_CTRL;
      s1_data <= '0;
      s1_ctrl <= '0;
      s1_aux  <= '0;
    end else if (bus.ce) begin
      s1_mode <= bus.mode;
      s1_data <= bus.data;
      s1_ctrl <= bus.ctrl;
      s1_aux  <= bus.aux;
    end
  end

  // Stage 2: transition-minimised word, with side info carried alongside
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_mode <= MODE_CTRL;
      s2_qm   <= '0;
      s2_ctrl <= '0;
      s2_aux  <= '0;
    end else if (bus.ce) begin
      s2_mode <= s1_mode;
      s2_qm   <= qm_next;
      s2_ctrl <= s1_ctrl;
      s2_aux  <= s1_aux;
    end
  end

  // Stage 3: final symbol with board polarity applied; disparity follows the unswapped symbol
  always_ff @(posedge clock) begin
    if (reset) begin
      tmds_q <= '0;
      cnt_q  <= '0;
    end else if (bus.ce) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tmds_q[10*i +: 10] <= enc_next[16*i +: 10] ^ {10{INVERT[i]}};
        cnt_q[6*i +: 6]    <= enc_next[16*i + 10 +: 6];
      end
    end
  end

  // Pipeline fill counter: saturates once all three stages hold real data
  always_ff @(posedge clock) begin
    if (reset)
      fill <= 2'd0;
    else if (bus.ce && (fill != 2'd3))
      fill <= fill + 2'd1;
  end

  assign bus.tmds       = tmds_q;
  assign bus.tmds_valid = (fill == 2'd3);

endmodule
`default_nettype wire
